// File: rtl/program_loader.sv
// Streams a program image into instruction memory, then enables fetch until halt, stop or budget expiry.
// Latency: each accepted byte appears on the write port one cycle later; RUN starts two cycles after the final byte.
// Backpressure: s_ready is high only while loading, and memory writes never stall, so every beat is accepted.
module program_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_DEPTH = 1024,
    parameter int RUN_CYCLES = 0
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] load_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  halt_i,
    input  logic                  stop_i,
    output logic                  fetch_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  halted,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [31:0]           run_cnt;

    logic start_ok;
    logic beat;
    logic final_beat;
    logic timeout;

    // Comparing base against DEPTH-len keeps the check free of overflow for any base.
    assign start_ok   = (load_len != '0) && (load_len <= DEPTH) &&
                        (base_addr <= (DEPTH - load_len));
    assign s_ready    = (state == LOAD);
    assign beat       = s_valid && s_ready;
    assign final_beat = (cnt == (len_q - ONE));
    assign timeout    = (RUN_CYCLES != 0) && (run_cnt == 32'(RUN_CYCLES - 1));

    assign busy        = (state != IDLE);
    assign fetch_valid = (state == RUN);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt     <= '0;
            run_cnt <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            halted  <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        if (start_ok) begin
                            base_q <= base_addr;
                            len_q  <= load_len;
                            cnt    <= '0;
                            state  <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (beat) begin
                        wr_en   <= 1'b1;
                        wr_addr <= base_q + cnt;
                        wr_data <= s_data;
                        cnt     <= cnt + ONE;
                        // An early s_last aborts, but its byte is still written.
                        if (final_beat) begin
                            state <= SETTLE;
                        end else if (s_last) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                SETTLE: begin
                    run_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt + 32'd1;
                    if (halt_i || stop_i || timeout) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        halted <= halt_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes, errors, run lengths and
// status snapshots; a single monitor process pops and compares them as the DUT presents outputs.
module tb_program_loader;

    logic        sys_clk;
    logic        rst;
    logic        load_start;
    logic [63:0] base_addr;
    logic [63:0] load_len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [7:0]  wr_data;
    logic        halt_i;
    logic        stop_i;
    logic        fetch_valid;
    logic        busy;
    logic        done;
    logic        halted;
    logic        err;

    program_loader #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(64),
        .DATA_DEPTH(1024),
        .RUN_CYCLES(20)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .load_start (load_start),
        .base_addr  (base_addr),
        .load_len   (load_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .halt_i     (halt_i),
        .stop_i     (stop_i),
        .fetch_valid(fetch_valid),
        .busy       (busy),
        .done       (done),
        .halted     (halted),
        .err        (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        string      name;
        logic [6:0] exp;
        int         kind;
    } snap_t;

    wr_t   wq[$];
    bit    errq[$];
    bit    doneq[$];
    int    runq[$];
    snap_t sq[$];

    int   n_checks = 0;
    int   n_fail = 0;
    logic probe = 1'b0;
    logic h = 1'b0;

    logic [7:0] sd[8];
    logic       sv[8];
    logic       sl[8];

    function automatic logic [6:0] status();
        return {busy, s_ready, wr_en, fetch_valid, done, err, halted};
    endfunction

    // Monitor: the only process that compares and counts.
    initial begin : monitor
        int    run_len;
        wr_t   w;
        snap_t s;
        bit    eh;
        int    el;
        run_len = 0;
        forever begin
            @(negedge sys_clk or posedge probe);
            if (probe) begin
                n_checks++;
                if (sq.size() == 0) begin
                    n_fail++;
                    $display("FAIL snapshot_queue: probe with no expectation queued");
                end else begin
                    s = sq.pop_front();
                    case (s.kind)
                        0: if (status() !== s.exp) begin
                            n_fail++;
                            $display("FAIL %s: status got %b expected %b (busy,s_ready,wr_en,fetch_valid,done,err,halted)",
                                     s.name, status(), s.exp);
                        end
                        1: begin
                            n_fail++;
                            $display("FAIL %s: bound expired waiting for done", s.name);
                        end
                        default: if (wq.size() + errq.size() + doneq.size() + runq.size() != 0) begin
                            n_fail++;
                            $display("FAIL %s: pending writes %0d errs %0d dones %0d runs %0d, expected all 0",
                                     s.name, wq.size(), errq.size(), doneq.size(), runq.size());
                        end
                    endcase
                end
            end else if (!rst) begin
                if (wr_en) begin
                    n_checks++;
                    if (wq.size() == 0) begin
                        n_fail++;
                        $display("FAIL write: unexpected write addr %0d data %h", wr_addr, wr_data);
                    end else begin
                        w = wq.pop_front();
                        if (wr_addr !== w.addr || wr_data !== w.data) begin
                            n_fail++;
                            $display("FAIL write: got addr %0d data %h expected addr %0d data %h",
                                     wr_addr, wr_data, w.addr, w.data);
                        end
                    end
                end
                if (err) begin
                    n_checks++;
                    if (errq.size() == 0) begin
                        n_fail++;
                        $display("FAIL err: unexpected err pulse got 1 expected 0");
                    end else begin
                        eh = errq.pop_front();
                    end
                end
                if (done) begin
                    n_checks++;
                    if (doneq.size() == 0) begin
                        n_fail++;
                        $display("FAIL done: unexpected done pulse");
                    end else begin
                        eh = doneq.pop_front();
                        if (halted !== eh) begin
                            n_fail++;
                            $display("FAIL done_halted: got %b expected %b", halted, eh);
                        end
                    end
                end
                if (fetch_valid) begin
                    run_len++;
                end else if (run_len != 0) begin
                    n_checks++;
                    if (runq.size() == 0) begin
                        n_fail++;
                        $display("FAIL run_length: unexpected run of %0d cycles", run_len);
                    end else begin
                        el = runq.pop_front();
                        if (run_len != el) begin
                            n_fail++;
                            $display("FAIL run_length: got %0d cycles expected %0d", run_len, el);
                        end
                    end
                    run_len = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic snap_kind(input string nm, input logic [6:0] e, input int kind);
        snap_t s;
        s.name = nm;
        s.exp  = e;
        s.kind = kind;
        sq.push_back(s);
        probe = 1'b1;
        #1;
        probe = 1'b0;
        #1;
    endtask

    task automatic snap(input string nm, input logic [6:0] e);
        snap_kind(nm, e, 0);
    endtask

    task automatic set_slot(input int i, input logic [7:0] d, input logic v, input logic l);
        sd[i] = d;
        sv[i] = v;
        sl[i] = l;
    endtask

    task automatic start(input logic [63:0] b, input logic [63:0] l);
        base_addr  = b;
        load_len   = l;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic stream(input int nslots, input logic [63:0] b);
        int  k;
        wr_t w;
        k = 0;
        for (int i = 0; i < nslots; i++) begin
            s_valid = sv[i];
            s_data  = sd[i];
            s_last  = sl[i];
            if (sv[i]) begin
                w.addr = b + 64'(k);
                w.data = sd[i];
                wq.push_back(w);
                k++;
            end
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic settle_and_run(input string tag);
        snap({tag, "_settle"}, {6'b101000, h});
        tick();
        snap({tag, "_run_entry"}, {6'b100100, h});
    endtask

    task automatic run_end(input string tag, input int wait_k, input int exp_len,
                           input logic hlt, input logic stp);
        repeat (wait_k) tick();
        halt_i = hlt;
        stop_i = stp;
        runq.push_back(exp_len);
        doneq.push_back(hlt);
        tick();
        halt_i = 1'b0;
        stop_i = 1'b0;
        h = hlt;
        snap({tag, "_done"}, {6'b000010, h});
        tick();
        snap({tag, "_after_done"}, {6'b000000, h});
    endtask

    task automatic reject(input string tag, input logic [63:0] b, input logic [63:0] l);
        start(b, l);
        errq.push_back(1'b1);
        snap(tag, {6'b000001, h});
        tick();
        snap({tag, "_clear"}, {6'b000000, h});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit got;
        rst        = 1'b1;
        load_start = 1'b0;
        base_addr  = '0;
        load_len   = '0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        s_last     = 1'b0;
        halt_i     = 1'b0;
        stop_i     = 1'b0;
        for (int i = 0; i < 8; i++) set_slot(i, 8'h00, 1'b0, 1'b0);

        repeat (2) @(posedge sys_clk);
        #1;
        snap("reset_state", 7'b0);
        rst = 1'b0;
        tick();
        snap("idle", 7'b0);

        // Back-to-back beats; load_start during RUN is ignored, then stop ends the run.
        set_slot(0, 8'h10, 1, 0); set_slot(1, 8'h60, 1, 0);
        set_slot(2, 8'hab, 1, 0); set_slot(3, 8'h00, 1, 1);
        start(64'd0, 64'd4);
        snap("t1_load_entry", {6'b110000, h});
        stream(4, 64'd0);
        settle_and_run("t1");
        base_addr  = 64'd0;
        load_len   = 64'd0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        snap("t1_start_ignored_in_run", {6'b100100, h});
        run_end("t1_stop", 1, 3, 1'b0, 1'b1);

        // Toggling valid: writes follow accepted beats only.
        set_slot(0, 8'h30, 1, 0); set_slot(1, 8'hee, 0, 0);
        set_slot(2, 8'h40, 1, 0); set_slot(3, 8'hee, 0, 0);
        set_slot(4, 8'h50, 1, 0); set_slot(5, 8'hee, 0, 0);
        set_slot(6, 8'h60, 1, 0);
        start(64'd100, 64'd4);
        stream(7, 64'd100);
        settle_and_run("t2");
        run_end("t2_stop", 0, 1, 1'b0, 1'b1);

        // Range rejects.
        reject("reject_1020_8", 64'd1020, 64'd8);
        reject("reject_len0", 64'd0, 64'd0);
        reject("reject_1021_4", 64'd1021, 64'd4);
        reject("reject_len1025", 64'd0, 64'd1025);

        // Exactly-fitting load at the top of memory, then halt on run cycle 5.
        set_slot(0, 8'h01, 1, 0); set_slot(1, 8'h02, 1, 0);
        set_slot(2, 8'h03, 1, 0); set_slot(3, 8'h04, 1, 0);
        start(64'd1020, 64'd4);
        stream(4, 64'd1020);
        settle_and_run("t4");
        run_end("t4_halt", 5, 6, 1'b1, 1'b0);

        // Single-byte load, run until the 20-cycle budget expires.
        set_slot(0, 8'h00, 1, 1);
        start(64'd8, 64'd1);
        stream(1, 64'd8);
        settle_and_run("t5");
        runq.push_back(20);
        doneq.push_back(1'b0);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (done) got = 1;
        end
        if (!got) begin
            snap_kind("t5_timeout_wait", 7'b0, 1);
        end else begin
            h = 1'b0;
            snap("t5_timeout_done", {6'b000010, h});
            tick();
            snap("t5_after_done", {6'b000000, h});
        end

        // Halt and stop together: halt wins.
        set_slot(0, 8'h11, 1, 0); set_slot(1, 8'h22, 1, 0);
        start(64'd0, 64'd2);
        stream(2, 64'd0);
        settle_and_run("t6");
        run_end("t6_halt_stop", 2, 3, 1'b1, 1'b1);

        // Early s_last on the second beat aborts after writing two bytes.
        set_slot(0, 8'haa, 1, 0); set_slot(1, 8'hbb, 1, 1);
        start(64'd40, 64'd4);
        stream(2, 64'd40);
        errq.push_back(1'b1);
        snap("abort", {6'b001001, h});
        tick();
        snap("abort_idle", {6'b000000, h});
        repeat (3) tick();
        snap("abort_no_run", {6'b000000, h});

        // Asynchronous reset in the middle of a load.
        set_slot(0, 8'hc1, 1, 0); set_slot(1, 8'hc2, 1, 0);
        start(64'd300, 64'd4);
        stream(2, 64'd300);
        @(negedge sys_clk);
        #1;
        snap("mid_load", {6'b111000, h});
        rst = 1'b1;
        #1;
        h = 1'b0;
        snap("async_reset", 7'b0);
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        tick();
        snap("post_reset_idle", 7'b0);
        set_slot(0, 8'he1, 1, 0); set_slot(1, 8'he2, 1, 0);
        start(64'd200, 64'd2);
        snap("t7_load_entry", {6'b110000, h});
        stream(2, 64'd200);
        settle_and_run("t7");
        run_end("t7_stop", 0, 1, 1'b0, 1'b1);

        tick();
        snap_kind("drain", 7'b0, 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
